// File: rtl/reg_file_8x8.sv
// ---------------------------------------------------------------------------
// reg_file_8x8
//   Operand-source register file for the single-cycle datapath. Eight general
//   registers (none hardwired to zero), one write port fed by the ALU result,
//   and two combinational read ports that drive the ALU DATA1/DATA2 inputs.
//
// Parameters
//   DATA_WIDTH  width of each register and of IN/OUT1/OUT2
//   ADDR_WIDTH  register index width; register count = 2**ADDR_WIDTH
//   BYPASS      1: a same-cycle write is forwarded to a matching read port
//               0: read ports return the stored value only
//
// Ports
//   CLK          system clock, all state changes on the rising edge
//   RESET        synchronous active-high clear of every register
//   IN           write-back data
//   INADDRESS    destination register index
//   WRITE        write enable, sampled at the rising edge
//   OUT1ADDRESS  read port 1 index
//   OUT2ADDRESS  read port 2 index
//   OUT1         read port 1 data (ALU DATA1)
//   OUT2         read port 2 data (ALU DATA2)
// ---------------------------------------------------------------------------
module reg_file_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] out1_s;
    logic [DATA_WIDTH-1:0] out2_s;

    // Read-port mux shared by both ports. Reset forces zero operands so the
    // ALU never sees stale data; bypass is only considered outside reset.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] raddr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  rst,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] result;
        result = stored;
        if (rst) begin
            result = '0;
        end else if ((BYPASS != 0) && wen && (raddr == waddr)) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Register array: reset clears everything and takes priority over a write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (WRITE) begin
            regs_r[INADDRESS] <= IN;
        end
    end

    // Combinational read ports, zero-cycle latency from the address inputs.
    always_comb begin
        out1_s = '0;
        out2_s = '0;
        out1_s = read_port(OUT1ADDRESS, regs_r[OUT1ADDRESS], RESET, WRITE, INADDRESS, IN);
        out2_s = read_port(OUT2ADDRESS, regs_r[OUT2ADDRESS], RESET, WRITE, INADDRESS, IN);
    end

    assign OUT1 = out1_s;
    assign OUT2 = out2_s;

endmodule

// File: tb/tb_reg_file_8x8.sv
// ---------------------------------------------------------------------------
// tb_reg_file_8x8
//   Directed bench for reg_file_8x8. Two instances share the same stimulus:
//   d0 is built with BYPASS=0, d1 with BYPASS=1, so same-cycle read/write
//   behaviour of both variants is checked against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_8x8;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic [2:0] in_addr;
    logic       write;
    logic [2:0] out1_addr;
    logic [2:0] out2_addr;
    logic [7:0] o1_0, o2_0, o1_1, o2_1;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0)) d0 (
        .CLK(clk), .RESET(reset), .IN(in_data), .INADDRESS(in_addr), .WRITE(write),
        .OUT1ADDRESS(out1_addr), .OUT2ADDRESS(out2_addr), .OUT1(o1_0), .OUT2(o2_0)
    );

    reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1)) d1 (
        .CLK(clk), .RESET(reset), .IN(in_data), .INADDRESS(in_addr), .WRITE(write),
        .OUT1ADDRESS(out1_addr), .OUT2ADDRESS(out2_addr), .OUT1(o1_1), .OUT2(o2_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1. Reset with a write request pending -------------------------
        reset = 1'b1; write = 1'b1; in_data = 8'hFF; in_addr = 3'd3;
        out1_addr = 3'd3; out2_addr = 3'd3;
        #1;
        chk("rst_force_d0_o1", o1_0, 8'h00);
        chk("rst_force_d1_o1", o1_1, 8'h00);
        chk("rst_force_d1_o2", o2_1, 8'h00);
        tick();
        tick();
        reset = 1'b0; write = 1'b0;
        for (int a = 0; a < 8; a++) begin
            out1_addr = 3'(a); out2_addr = 3'(a);
            #1;
            chk("rst_d0_o1", o1_0, 8'h00);
            chk("rst_d0_o2", o2_0, 8'h00);
            chk("rst_d1_o1", o1_1, 8'h00);
            chk("rst_d1_o2", o2_1, 8'h00);
        end

        // ---- 2. Full write / readback --------------------------------------
        for (int i = 0; i < 8; i++) begin
            in_addr = 3'(i); in_data = 8'h10 + 8'(i); write = 1'b1;
            tick();
        end
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out1_addr = 3'(i); out2_addr = 3'(7 - i);
            #1;
            chk("wr_d0_o1", o1_0, 8'h10 + 8'(i));
            chk("wr_d0_o2", o2_0, 8'h17 - 8'(i));
            chk("wr_d1_o1", o1_1, 8'h10 + 8'(i));
            chk("wr_d1_o2", o2_1, 8'h17 - 8'(i));
        end

        // ---- 3/4. Same-cycle read/write ------------------------------------
        in_addr = 3'd2; in_data = 8'h05; write = 1'b1;
        tick();
        write = 1'b0; out1_addr = 3'd2; out2_addr = 3'd2;
        #1;
        chk("pre_d0_o1", o1_0, 8'h05);
        in_data = 8'hA0; write = 1'b1;
        #1;
        chk("rw_nobyp_o1", o1_0, 8'h05);
        chk("rw_nobyp_o2", o2_0, 8'h05);
        chk("rw_byp_o1", o1_1, 8'hA0);
        chk("rw_byp_o2", o2_1, 8'hA0);
        tick();
        write = 1'b0;
        #1;
        chk("rw_after_d0", o1_0, 8'hA0);
        chk("rw_after_d1", o1_1, 8'hA0);
        out2_addr = 3'd4;
        #1;
        chk("rw_other_d0", o2_0, 8'h14);
        chk("rw_other_d1", o2_1, 8'h14);

        reset = 1'b1; write = 1'b1; in_data = 8'hA0; in_addr = 3'd2; out2_addr = 3'd2;
        #1;
        chk("rst_byp_d1_o1", o1_1, 8'h00);
        chk("rst_byp_d1_o2", o2_1, 8'h00);
        chk("rst_byp_d0_o1", o1_0, 8'h00);
        tick();
        reset = 1'b0; write = 1'b0;
        #1;
        chk("rst_wr_d0_reg2", o1_0, 8'h00);
        chk("rst_wr_d1_reg2", o1_1, 8'h00);

        // ---- 5. Dual port and overwrite ------------------------------------
        out1_addr = 3'd5; out2_addr = 3'd5;
        in_addr = 3'd5; in_data = 8'h11; write = 1'b1;
        tick();
        in_data = 8'h22;
        #1;
        chk("ow1_d0_o1", o1_0, 8'h11);
        chk("ow1_d0_o2", o2_0, 8'h11);
        chk("ow1_d1_o1_byp", o1_1, 8'h22);
        tick();
        write = 1'b0; in_data = 8'h33;
        #1;
        chk("ow2_d0_o1", o1_0, 8'h22);
        chk("ow2_d0_o2", o2_0, 8'h22);
        chk("ow2_d1_o1", o1_1, 8'h22);
        chk("ow2_d1_o2", o2_1, 8'h22);
        tick();
        chk("nowr_d0_o1", o1_0, 8'h22);
        chk("nowr_d1_o2", o2_1, 8'h22);

        // ---- 6. Mid-run reset ----------------------------------------------
        for (int i = 0; i < 8; i++) begin
            in_addr = 3'(i); in_data = 8'hC0 + 8'(i); write = 1'b1;
            tick();
        end
        write = 1'b0; out1_addr = 3'd7; out2_addr = 3'd1;
        #1;
        chk("load_d0_o1", o1_0, 8'hC7);
        chk("load_d1_o2", o2_1, 8'hC1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            out1_addr = 3'(a); out2_addr = 3'(7 - a);
            #1;
            chk("mrst_d0_o1", o1_0, 8'h00);
            chk("mrst_d0_o2", o2_0, 8'h00);
            chk("mrst_d1_o1", o1_1, 8'h00);
            chk("mrst_d1_o2", o2_1, 8'h00);
        end
        in_addr = 3'd6; in_data = 8'h7E; write = 1'b1;
        tick();
        write = 1'b0;
        for (int a = 0; a < 8; a++) begin
            out1_addr = 3'(a); out2_addr = 3'(a);
            #1;
            chk("post_d0_o1", o1_0, (a == 6) ? 8'h7E : 8'h00);
            chk("post_d0_o2", o2_0, (a == 6) ? 8'h7E : 8'h00);
            chk("post_d1_o1", o1_1, (a == 6) ? 8'h7E : 8'h00);
            chk("post_d1_o2", o2_1, (a == 6) ? 8'h7E : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
